// File: rtl/pll_reconfig_ctrl_if.sv
// Reconfiguration request channel for the PLL supervisor.
// Requester drives the selects and valid; the supervisor answers with ready.
interface pll_reconfig_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [6:0] cfg_mdsel;
    logic [6:0] cfg_odsel0;

    modport master (
        output cfg_valid,
        output cfg_mdsel,
        output cfg_odsel0,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_mdsel,
        input  cfg_odsel0,
        output cfg_ready
    );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL supervisor: reset sequencing, lock wait with retry, stability
// qualification and runtime MDSEL/ODSEL0 reconfiguration.
module pll_reconfig_ctrl #(
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         STABLE_CYCLES = 1024,
    parameter int         MAX_RETRY     = 3,
    parameter logic [6:0] MDSEL_DEF     = 7'd28,
    parameter logic [6:0] ODSEL0_DEF    = 7'd2
) (
    input  logic                clkin,
    input  logic                reset,
    pll_reconfig_ctrl_if.slave  cfg,
    input  logic                pll_lock,
    output logic                pll_reset,
    output logic                pll_pwd,
    output logic [6:0]          pll_mdsel,
    output logic [6:0]          pll_odsel0,
    output logic                clk_ok,
    output logic                user_reset,
    output logic [1:0]          retry_cnt,
    output logic                err,
    output logic [2:0]          state
);

    localparam int CMAX0 = (LOCK_TIMEOUT > STABLE_CYCLES) ?
                           LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int CMAX  = (CMAX0 > RST_CYCLES) ? CMAX0 : RST_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  sync_q;
    logic [1:0]  retry_q, retry_d, retry_inc;
    logic [6:0]  mdsel_q, mdsel_d;
    logic [6:0]  odsel_q, odsel_d;
    logic        pll_reset_q, pll_reset_d;
    logic        pwd_q, pwd_d;
    logic        clk_ok_q, clk_ok_d;
    logic        user_rst_q, user_rst_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        lock_s;
    logic        hs;

    assign lock_s    = sync_q[1];
    assign hs        = cfg.cfg_valid && ready_q;
    assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            sync_q      <= '0;
            retry_q     <= '0;
            mdsel_q     <= MDSEL_DEF;
            odsel_q     <= ODSEL0_DEF;
            pll_reset_q <= 1'b1;
            pwd_q       <= 1'b0;
            clk_ok_q    <= 1'b0;
            user_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[0], pll_lock};
            retry_q     <= retry_d;
            mdsel_q     <= mdsel_d;
            odsel_q     <= odsel_d;
            pll_reset_q <= pll_reset_d;
            pwd_q       <= pwd_d;
            clk_ok_q    <= clk_ok_d;
            user_rst_q  <= user_rst_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        mdsel_d = mdsel_q;
        odsel_d = odsel_q;
        unique case (state_q)
            S_RST: begin
                if (cnt_q == CW'(RST_CYCLES - 1))
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    state_d = (int'(retry_inc) == MAX_RETRY) ?
                              S_FAIL : S_RST;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                // A request beats a simultaneous lock loss: one relock covers both.
                if (hs) begin
                    mdsel_d = cfg.cfg_mdsel;
                    odsel_d = cfg.cfg_odsel0;
                    state_d = S_RST;
                end else if (!lock_s) begin
                    state_d = S_RST;
                end
            end
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (state_d != state_q || state_q == S_RUN || state_q == S_FAIL)
            cnt_d = '0;
        pll_reset_d = (state_d == S_RST) || (state_d == S_FAIL);
        pwd_d       = (state_d == S_FAIL);
        clk_ok_d    = (state_d == S_RUN);
        user_rst_d  = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        err_d       = err_q || (state_d == S_FAIL);
    end

    assign cfg.cfg_ready = ready_q;
    assign pll_reset     = pll_reset_q;
    assign pll_pwd       = pwd_q;
    assign pll_mdsel     = mdsel_q;
    assign pll_odsel0    = odsel_q;
    assign clk_ok        = clk_ok_q;
    assign user_reset    = user_rst_q;
    assign retry_cnt     = retry_q;
    assign err           = err_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with shortened timing parameters.
// Expected values are hand-derived cycle counts from the sequencing rules.
module tb_pll_reconfig_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset, pll_pwd, clk_ok, user_reset, err;
    logic [6:0] pll_mdsel, pll_odsel0;
    logic [1:0] retry_cnt;
    logic [2:0] state;
    int         tests = 0;
    int         fails = 0;

    pll_reconfig_ctrl_if cfg_if ();

    pll_reconfig_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2),
        .MDSEL_DEF     (7'd28),
        .ODSEL0_DEF    (7'd2)
    ) dut (
        .clkin      (clk),
        .reset      (reset),
        .cfg        (cfg_if),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_pwd    (pll_pwd),
        .pll_mdsel  (pll_mdsel),
        .pll_odsel0 (pll_odsel0),
        .clk_ok     (clk_ok),
        .user_reset (user_reset),
        .retry_cnt  (retry_cnt),
        .err        (err),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] exp, input int budget,
                              input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (state !== exp && n < budget);
        chk(tag, 32'(state), 32'(exp));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".state"}, 32'(state), 32'd0);
        chk({tag, ".pll_reset"}, 32'(pll_reset), 32'd1);
        chk({tag, ".pll_pwd"}, 32'(pll_pwd), 32'd0);
        chk({tag, ".mdsel"}, 32'(pll_mdsel), 32'd28);
        chk({tag, ".odsel0"}, 32'(pll_odsel0), 32'd2);
        chk({tag, ".cfg_ready"}, 32'(cfg_if.cfg_ready), 32'd0);
        chk({tag, ".clk_ok"}, 32'(clk_ok), 32'd0);
        chk({tag, ".user_reset"}, 32'(user_reset), 32'd1);
        chk({tag, ".retry"}, 32'(retry_cnt), 32'd0);
        chk({tag, ".err"}, 32'(err), 32'd0);
    endtask

    initial begin
        reset             = 1'b1;
        pll_lock          = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_mdsel  = 7'd0;
        cfg_if.cfg_odsel0 = 7'd0;
        repeat (3) tick();
        chk_reset("por");

        // Power-up: 4 reset cycles, lock raised 10 cycles after release
        reset = 1'b0;
        repeat (3) tick();
        chk("pu.rst_hi", 32'(pll_reset), 32'd1);
        chk("pu.rst_state", 32'(state), 32'd0);
        tick();
        chk("pu.rst_lo", 32'(pll_reset), 32'd0);
        chk("pu.wait", 32'(state), 32'd1);
        repeat (6) tick();
        pll_lock = 1'b1;
        tick();
        chk("pu.sync1", 32'(state), 32'd1);
        tick();
        chk("pu.sync2", 32'(state), 32'd1);
        tick();
        chk("pu.stable", 32'(state), 32'd2);
        repeat (7) tick();
        chk("pu.st7", 32'(state), 32'd2);
        chk("pu.st7_ok", 32'(clk_ok), 32'd0);
        tick();
        chk("pu.run", 32'(state), 32'd3);
        chk("pu.clk_ok", 32'(clk_ok), 32'd1);
        chk("pu.user_rst", 32'(user_reset), 32'd0);
        chk("pu.ready", 32'(cfg_if.cfg_ready), 32'd1);

        // Reconfig
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_mdsel  = 7'd40;
        cfg_if.cfg_odsel0 = 7'd4;
        tick();
        cfg_if.cfg_valid = 1'b0;
        chk("rc.mdsel", 32'(pll_mdsel), 32'd40);
        chk("rc.odsel", 32'(pll_odsel0), 32'd4);
        chk("rc.clk_ok", 32'(clk_ok), 32'd0);
        chk("rc.ready", 32'(cfg_if.cfg_ready), 32'd0);
        chk("rc.state", 32'(state), 32'd0);
        chk("rc.user_rst", 32'(user_reset), 32'd1);
        repeat (12) tick();
        chk("rc.st12", 32'(state), 32'd2);
        tick();
        chk("rc.run", 32'(state), 32'd3);
        chk("rc.mdsel_run", 32'(pll_mdsel), 32'd40);
        chk("rc.odsel_run", 32'(pll_odsel0), 32'd4);

        // Lock loss in RUN, then a one-cycle glitch in STABLE
        pll_lock = 1'b0;
        wait_state(3'd0, 10, "ll.rst");
        chk("ll.clk_ok", 32'(clk_ok), 32'd0);
        chk("ll.mdsel", 32'(pll_mdsel), 32'd40);
        pll_lock = 1'b1;
        wait_state(3'd2, 20, "gl.stable");
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        chk("gl.still", 32'(state), 32'd2);
        tick();
        chk("gl.wait", 32'(state), 32'd1);
        chk("gl.retry", 32'(retry_cnt), 32'd0);
        tick();
        chk("gl.restable", 32'(state), 32'd2);
        repeat (7) tick();
        chk("gl.st7", 32'(state), 32'd2);
        tick();
        chk("gl.run", 32'(state), 32'd3);

        // Timeout and fail
        pll_lock = 1'b0;
        wait_state(3'd0, 10, "to.rst");
        wait_state(3'd1, 10, "to.wait");
        repeat (19) tick();
        chk("to.w19", 32'(state), 32'd1);
        tick();
        chk("to.rst1", 32'(state), 32'd0);
        chk("to.retry1", 32'(retry_cnt), 32'd1);
        repeat (4) tick();
        chk("to.wait2", 32'(state), 32'd1);
        repeat (19) tick();
        chk("to.w2_19", 32'(state), 32'd1);
        tick();
        chk("to.fail", 32'(state), 32'd4);
        chk("to.err", 32'(err), 32'd1);
        chk("to.pwd", 32'(pll_pwd), 32'd1);
        chk("to.prst", 32'(pll_reset), 32'd1);
        chk("to.retry2", 32'(retry_cnt), 32'd2);
        chk("to.clk_ok", 32'(clk_ok), 32'd0);
        pll_lock = 1'b1;
        repeat (10) tick();
        chk("to.hold", 32'(state), 32'd4);
        chk("to.err_hold", 32'(err), 32'd1);
        reset = 1'b1;
        tick();
        chk_reset("fr");
        reset = 1'b0;

        // Lock loss and request arriving in the same cycle
        wait_state(3'd3, 40, "si.run");
        pll_lock = 1'b0;
        repeat (2) tick();
        chk("si.pre", 32'(state), 32'd3);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_mdsel  = 7'd50;
        cfg_if.cfg_odsel0 = 7'd6;
        tick();
        cfg_if.cfg_valid = 1'b0;
        pll_lock = 1'b1;
        chk("si.state", 32'(state), 32'd0);
        chk("si.mdsel", 32'(pll_mdsel), 32'd50);
        chk("si.odsel", 32'(pll_odsel0), 32'd6);
        repeat (3) tick();
        chk("si.rst3", 32'(state), 32'd0);
        chk("si.prst3", 32'(pll_reset), 32'd1);
        tick();
        chk("si.wait", 32'(state), 32'd1);
        tick();
        chk("si.stable", 32'(state), 32'd2);
        repeat (8) tick();
        chk("si.run2", 32'(state), 32'd3);
        chk("si.mdsel2", 32'(pll_mdsel), 32'd50);
        chk("si.odsel2", 32'(pll_odsel0), 32'd6);

        // Reset during WAIT_LOCK after a reconfig
        pll_lock          = 1'b0;
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_mdsel  = 7'd60;
        cfg_if.cfg_odsel0 = 7'd3;
        tick();
        cfg_if.cfg_valid = 1'b0;
        chk("mr.mdsel", 32'(pll_mdsel), 32'd60);
        repeat (4) tick();
        chk("mr.wait", 32'(state), 32'd1);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mdsel = 7'd70;
        tick();
        chk("mr.noacc", 32'(pll_mdsel), 32'd60);
        chk("mr.noready", 32'(cfg_if.cfg_ready), 32'd0);
        reset = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        tick();
        chk_reset("mr");
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
